// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: FSM state encoding, master
//   ids and default bus widths.
//   Optional feature macro used by this block: DMEM_ARB_RR_EN (see dmem_arb_pick).
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int DARB_ADDR_W  = 32;
    localparam int DARB_DATA_W  = 32;
    localparam int DARB_MEMOP_W = 3;

    typedef enum logic {
        DARB_IDLE   = 1'b0,
        DARB_ACCESS = 1'b1
    } darb_state_e;

    // Master ids double as the select value and the round-robin "last" value.
    localparam logic DARB_M0 = 1'b0;
    localparam logic DARB_M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles both master request ports and the memory-side bus of the arbiter.
//   Modports:
//     slave  - arbiter view: takes mN_* commands and mem_rdata, drives gnt,
//              rvalid, rdata and the mem_* command outputs.
//     master - surrounding SoC / testbench view (mirror of slave).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEMOP_W = 3
);
    logic               m0_req,    m1_req;
    logic               m0_we,     m1_we;
    logic [ADDR_W-1:0]  m0_addr,   m1_addr;
    logic [MEMOP_W-1:0] m0_memop,  m1_memop;
    logic [DATA_W-1:0]  m0_wdata,  m1_wdata;
    logic               m0_gnt,    m1_gnt;
    logic               m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0]  m0_rdata,  m1_rdata;

    logic               mem_w;
    logic [ADDR_W-1:0]  mem_addr;
    logic [MEMOP_W-1:0] mem_memop;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_memop, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_memop, m1_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_w, mem_addr, mem_memop, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_memop, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_memop, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_w, mem_addr, mem_memop, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
//   Combinational winner selection between the two masters.
//   Ports:
//     req_i[1:0]  live request lines (bit N = master N)
//     last_i      most recently granted master (round-robin history)
//     winner_o    id of the selected master (only meaningful when any_o=1)
//     any_o       at least one request present
//   Macro DMEM_ARB_RR_EN: defined -> ties go to the master that was not granted
//   last; undefined -> M0 always wins ties and last_i is ignored.
// -----------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       any_o
);

`ifndef DMEM_ARB_RR_EN
    // History is kept by the top regardless; fixed priority does not need it.
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        any_o    = |req_i;
        winner_o = DARB_M0;
        case (req_i)
            2'b01:   winner_o = DARB_M0;
            2'b10:   winner_o = DARB_M1;
`ifdef DMEM_ARB_RR_EN
            2'b11:   winner_o = ~last_i;
`else
            2'b11:   winner_o = DARB_M0;
`endif
            default: winner_o = DARB_M0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between M0 (CPU data port) and M1
//   (DMA/debug loader). One access per cycle while requests keep arriving;
//   read data is returned registered one cycle after the grant.
//   Ports:
//     clk    system clock, all state on rising edge
//     reset  synchronous, active-high
//     bus    dmem_arbiter_if.slave: mN_req/we/addr/memop/wdata in,
//            mN_gnt/rvalid/rdata out, mem_w/addr/memop/wdata out, mem_rdata in
//   Tie-break policy selected by macro DMEM_ARB_RR_EN (inside dmem_arb_pick).
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DARB_ADDR_W,
    parameter int DATA_W  = DARB_DATA_W,
    parameter int MEMOP_W = DARB_MEMOP_W
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    darb_state_e       state_q;
    logic              sel_q;
    logic              last_q;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q [2];

    logic [1:0] req;
    logic       access;
    logic       sel_we;
    logic       pick_last;
    logic       winner;
    logic       any;

    assign req    = {bus.m1_req, bus.m0_req};
    assign access = (state_q == DARB_ACCESS);
    assign sel_we = sel_q ? bus.m1_we : bus.m0_we;

    // The granted master's held req counts as a fresh request, and last is
    // updated to sel on the same edge, so the tie-break sees sel as history
    // while in ACCESS. This gives strict alternation under round robin.
    assign pick_last = access ? sel_q : last_q;

    dmem_arb_pick u_pick (
        .req_i    (req),
        .last_i   (pick_last),
        .winner_o (winner),
        .any_o    (any)
    );

    // Memory command comes straight from the selected master's live inputs;
    // masters hold them stable through their grant cycle.
    assign bus.mem_addr  = access ? (sel_q ? bus.m1_addr  : bus.m0_addr)  : '0;
    assign bus.mem_memop = access ? (sel_q ? bus.m1_memop : bus.m0_memop) : '0;
    assign bus.mem_wdata = access ? (sel_q ? bus.m1_wdata : bus.m0_wdata) : '0;

    // Reset suppresses the in-flight access: no write strobe, no grant.
    assign bus.mem_w  = access & ~reset & sel_we;
    assign bus.m0_gnt = access & ~reset & (sel_q == DARB_M0);
    assign bus.m1_gnt = access & ~reset & (sel_q == DARB_M1);

    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DARB_IDLE;
            sel_q      <= DARB_M0;
            last_q     <= DARB_M1;   // M0 wins the first tie
            rvalid_q   <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            rvalid_q <= '0;
            case (state_q)
                DARB_IDLE: begin
                    if (any) begin
                        sel_q   <= winner;
                        state_q <= DARB_ACCESS;
                    end
                end
                DARB_ACCESS: begin
                    if (!sel_we) begin
                        rdata_q[sel_q]  <= bus.mem_rdata;
                        rvalid_q[sel_q] <= 1'b1;
                    end
                    last_q <= sel_q;
                    if (any) begin
                        sel_q <= winner;      // back-to-back, no IDLE bubble
                    end else begin
                        state_q <= DARB_IDLE;
                    end
                end
                default: state_q <= DARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed scenarios followed by constrained-random traffic against a
//   transaction-level model: a request seen at a clock edge is granted in the
//   following cycle to the arbitration winner, reads return one cycle later.
//   Honours DMEM_ARB_RR_EN for the tie-break expectation.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // master-side drive
    logic [1:0]  req = '0;
    logic [1:0]  we  = '0;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [2:0]  memop [2];

    assign bus.m0_req   = req[0];
    assign bus.m1_req   = req[1];
    assign bus.m0_we    = we[0];
    assign bus.m1_we    = we[1];
    assign bus.m0_addr  = addr[0];
    assign bus.m1_addr  = addr[1];
    assign bus.m0_wdata = wdata[0];
    assign bus.m1_wdata = wdata[1];
    assign bus.m0_memop = memop[0];
    assign bus.m1_memop = memop[1];

    // word-addressed memory, 256 words
    function automatic logic [31:0] init_word(int i);
        logic [31:0] v;
        v = 32'h9E37_79B9 * (i + 1);
        if (i == 4) v = 32'h1122_3344;
        return v;
    endfunction

    logic [31:0] mem [256];
    logic        loaded = 1'b0;
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (bus.mem_w) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    // reference model state
    logic [31:0] mmem [256];
    logic [1:0]  exp_gnt = '0;
    logic [1:0]  exp_rv  = '0;
    logic [31:0] exp_rd  [2];
    logic        last    = 1'b1;

    int n_chk = 0;
    int n_err = 0;
    int gcnt1 = 0;

    function automatic logic [1:0] win(logic [1:0] r, logic l);
        if (r == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            return l ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs mid-cycle, then apply the model's edge update.
    task automatic tick();
        logic [1:0]  g;
        logic        s;
        logic [31:0] ea, ew;
        logic [2:0]  em;
        logic        ewr;
        @(negedge clk);
        g   = exp_gnt & {2{~rst}};
        ea  = '0; ew = '0; em = '0; ewr = 1'b0; s = 1'b0;
        if (exp_gnt != 2'b00) begin
            s   = exp_gnt[1];
            ea  = addr[s];
            ew  = wdata[s];
            em  = memop[s];
            ewr = we[s] & ~rst;
        end
        chk("m0_gnt",    {31'd0, bus.m0_gnt},    {31'd0, g[0]});
        chk("m1_gnt",    {31'd0, bus.m1_gnt},    {31'd0, g[1]});
        chk("mem_w",     {31'd0, bus.mem_w},     {31'd0, ewr});
        chk("mem_addr",  bus.mem_addr,           ea);
        chk("mem_memop", {29'd0, bus.mem_memop}, {29'd0, em});
        chk("mem_wdata", bus.mem_wdata,          ew);
        chk("m0_rvalid", {31'd0, bus.m0_rvalid}, {31'd0, exp_rv[0]});
        chk("m1_rvalid", {31'd0, bus.m1_rvalid}, {31'd0, exp_rv[1]});
        chk("m0_rdata",  bus.m0_rdata,           exp_rd[0]);
        chk("m1_rdata",  bus.m1_rdata,           exp_rd[1]);
        if (bus.m1_gnt === 1'b1) gcnt1++;
        @(posedge clk);
        if (rst) begin
            exp_gnt   = '0;
            exp_rv    = '0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            last      = 1'b1;
        end else begin
            exp_rv = exp_gnt & ~we;
            for (int n = 0; n < 2; n++) begin
                if (exp_rv[n]) exp_rd[n] = mmem[addr[n][9:2]];
                if (exp_gnt[n] && we[n]) mmem[addr[n][9:2]] = wdata[n];
                if (exp_gnt[n]) last = n[0];
            end
            exp_gnt = win(req, last);
        end
        #1;
    endtask

    task automatic set_cmd(int n, logic w, logic [31:0] a, logic [31:0] d);
        we[n]    = w;
        addr[n]  = a;
        wdata[n] = d;
        memop[n] = 3'(n + 2);
    endtask

    initial begin
        logic [1:0] g;
        for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        set_cmd(0, 1'b0, 32'h0, 32'h0);
        set_cmd(1, 1'b0, 32'h0, 32'h0);

        @(posedge clk); #1;     // leave the X state under reset
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: single M0 read of 0x10
        set_cmd(0, 1'b0, 32'h10, 32'h0); req[0] = 1'b1;
        tick();                             // request cycle
        req[0] = 1'b0; tick();              // grant cycle
        tick();                             // rvalid cycle
        chk("t1_rdata", bus.m0_rdata, 32'h1122_3344);

        // 2: M1 writes 0x20, then M0 reads it back
        set_cmd(1, 1'b1, 32'h20, 32'hDEAD_BEEF); req[1] = 1'b1;
        tick();
        req[1] = 1'b0; tick();
        set_cmd(0, 1'b0, 32'h20, 32'h0); req[0] = 1'b1;
        tick();
        req[0] = 1'b0; tick();
        tick();
        chk("t2_rdata", bus.m0_rdata, 32'hDEAD_BEEF);

        // 3/4: continuous contention
        set_cmd(0, 1'b0, 32'h10, 32'h0);
        set_cmd(1, 1'b0, 32'h20, 32'h0);
        req = 2'b11;
        tick();
        gcnt1 = 0;
        repeat (4) tick();
`ifdef DMEM_ARB_RR_EN
        chk("t3_m1_gnts", gcnt1, 2);
`else
        chk("t4_m1_gnts", gcnt1, 0);
`endif
        req[0] = 1'b0;
        repeat (3) tick();
        req[1] = 1'b0;
        repeat (2) tick();

        // 5: reset lands on the M1 write grant cycle
        set_cmd(1, 1'b1, 32'h30, 32'hCAFE_F00D); req[1] = 1'b1;
        tick();
        rst = 1'b1; req[1] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t5_mem30", mem[12], init_word(12));

        // 6: M1 request waiting behind an M0 read
        set_cmd(0, 1'b0, 32'h10, 32'h0); req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        set_cmd(1, 1'b0, 32'h20, 32'h0); req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        repeat (3) tick();

        // random traffic with occasional reset
        repeat (400) begin
            rst = ($urandom_range(0, 49) == 0);
            g   = exp_gnt & {2{~rst}};
            for (int n = 0; n < 2; n++) begin
                if (!(req[n] && !g[n])) begin
                    if (!req[n])
                        set_cmd(n, 1'($urandom_range(0, 1)),
                                32'($urandom_range(0, 255)) << 2, $urandom);
                    req[n] = 1'($urandom_range(0, 1));
                end
            end
            tick();
        end
        rst = 1'b0;
        req = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
